// File: rtl/bus_arbiter_if.sv
// Two-port memory arbiter bus: requester ports, grant/ack handshake and memory side.
interface bus_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // Requester side: port 0 is the CPU, port 1 is the loader/DMA
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;

    // Memory side
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, ack0, ack1, rdata, busy,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    // Environment view: requesters plus the memory read-data return
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, ack0, ack1, rdata, busy,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port single-memory arbiter: fixed port-0 priority with a starvation
// limit for port 1; each access is one ACCESS cycle plus one RESP cycle.
module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_arbiter_if.slave bus
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          owner;
    logic          ownerWe;
    logic [CntW-1:0] starveCnt;

    logic          gnt0Q;
    logic          gnt1Q;
    logic          ack0Q;
    logic          ack1Q;
    logic [AW-1:0] memAddrQ;
    logic [DW-1:0] memWdataQ;
    logic          memWeQ;
    logic          memReQ;

    logic          anyReq;
    logic          pickPort;
    logic          pickWe;
    logic [AW-1:0] pickAddr;
    logic [DW-1:0] pickWdata;
    logic [CntW-1:0] nextCnt;

    // Arbitration decision and starvation-counter update for a grant issued this edge
    always_comb begin
        anyReq    = bus.req0 | bus.req1;
        pickPort  = 1'b0;
        nextCnt   = '0;

        if (bus.req0 && bus.req1) begin
            pickPort = (starveCnt == CntW'(STARVE_LIMIT));
        end else if (bus.req1) begin
            pickPort = 1'b1;
        end

        // Port 0 winning over a waiting port 1 moves the counter toward the limit
        if (!pickPort && bus.req1) begin
            nextCnt = (starveCnt == CntW'(STARVE_LIMIT)) ? starveCnt : starveCnt + CntW'(1);
        end

        pickWe    = pickPort ? bus.we1    : bus.we0;
        pickAddr  = pickPort ? bus.addr1  : bus.addr0;
        pickWdata = pickPort ? bus.wdata1 : bus.wdata0;
    end

    // State, owner, counter and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            ownerWe   <= 1'b0;
            starveCnt <= '0;
            gnt0Q     <= 1'b0;
            gnt1Q     <= 1'b0;
            ack0Q     <= 1'b0;
            ack1Q     <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            memWeQ    <= 1'b0;
            memReQ    <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    ack0Q     <= 1'b0;
                    ack1Q     <= 1'b0;
                    gnt0Q     <= 1'b0;
                    gnt1Q     <= 1'b0;
                    memAddrQ  <= '0;
                    memWdataQ <= '0;
                    memWeQ    <= 1'b0;
                    memReQ    <= 1'b0;
                    state     <= IDLE;
                    if (anyReq) begin
                        state     <= ACCESS;
                        owner     <= pickPort;
                        ownerWe   <= pickWe;
                        starveCnt <= nextCnt;
                        gnt0Q     <= ~pickPort;
                        gnt1Q     <= pickPort;
                        memAddrQ  <= pickAddr;
                        memWdataQ <= pickWdata;
                        memWeQ    <= pickWe;
                        memReQ    <= ~pickWe;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    memAddrQ  <= '0;
                    memWdataQ <= '0;
                    memWeQ    <= 1'b0;
                    memReQ    <= 1'b0;
                    ack0Q     <= ~owner;
                    ack1Q     <= owner;
                end
                default: begin
                    state <= IDLE;
                    gnt0Q <= 1'b0;
                    gnt1Q <= 1'b0;
                    ack0Q <= 1'b0;
                    ack1Q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0Q;
    assign bus.gnt1      = gnt1Q;
    assign bus.ack0      = ack0Q;
    assign bus.ack1      = ack1Q;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;
    assign bus.mem_we    = memWeQ;
    assign bus.mem_re    = memReQ;
    assign bus.busy      = (state != IDLE);

    // Memory returns read data in the RESP cycle; pass it through so it lines up with ack
    assign bus.rdata = (state == RESP && !ownerWe) ? bus.mem_rdata : '0;

    // Protocol invariants
    assert property (@(posedge clk) disable iff (!reset_n) !(bus.gnt0 && bus.gnt1));
    assert property (@(posedge clk) disable iff (!reset_n) !(bus.ack0 && bus.ack1));
    assert property (@(posedge clk) disable iff (!reset_n) !(bus.mem_we && bus.mem_re));
    assert property (@(posedge clk) disable iff (!reset_n) bus.mem_we |-> (state == ACCESS));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus a random two-port run.
module tb_bus_arbiter;

    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int RAND_CYCLES = 10000;

    logic clk;
    logic reset_n;

    bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: read data appears the cycle after mem_re
    logic [7:0] tbMem [256];
    logic [7:0] memRdataQ;
    logic       memInit;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) tbMem[i] <= 8'h00;
            memRdataQ <= 8'h00;
        end else begin
            if (bus.mem_we) tbMem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_re) memRdataQ <= tbMem[bus.mem_addr];
        end
    end

    assign bus.mem_rdata = memRdataQ;

    // Reference memory and per-port expected-ack queues
    logic [7:0] refMem [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    int checkCount;
    int failCount;
    int exclViol;
    int idleBusViol;
    int weCycles;

    int grantSeq [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

    bit waiting [2];
    int waited  [2];
    int waitCyc [2];
    int idleCnt [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outsVec();
        return {1'b0, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy, bus.mem_we, bus.mem_re,
                bus.rdata, bus.mem_addr, bus.mem_wdata};
    endfunction

    function automatic logic ackOf(input int p);
        return (p == 1) ? bus.ack1 : bus.ack0;
    endfunction

    task automatic drivePort(input int p, input logic r, input logic w,
                             input logic [7:0] a, input logic [7:0] d);
        if (p == 1) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic pushExp(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] e;
        e = w ? 8'h00 : refMem[a];
        if (w) refMem[a] = d;
        if (p == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    // Advance to the next falling edge and score whatever the DUT completed
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (bus.gnt0 && bus.gnt1) exclViol++;
        if (bus.ack0 && bus.ack1) exclViol++;
        if (!bus.mem_we && !bus.mem_re && (bus.mem_addr != '0 || bus.mem_wdata != '0)) idleBusViol++;
        if (bus.mem_we) weCycles++;
        if (bus.ack0) begin
            if (q0.size() == 0) checkVal("ack0Unexpected", 32'(q0.size()), 1);
            else begin
                e = q0.pop_front();
                checkVal("rdata0", 32'(bus.rdata), 32'(e));
            end
        end
        if (bus.ack1) begin
            if (q1.size() == 0) checkVal("ack1Unexpected", 32'(q1.size()), 1);
            else begin
                e = q1.pop_front();
                checkVal("rdata1", 32'(bus.rdata), 32'(e));
            end
        end
    endtask

    task automatic doAccess(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        bit done;
        done = 1'b0;
        pushExp(p, w, a, d);
        drivePort(p, 1'b1, w, a, d);
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            if (ackOf(p)) begin
                done = 1'b1;
                drivePort(p, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        if (!done) begin
            checkVal("accessTimeout", 32'(done), 1);
            drivePort(p, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic issueRandom(input int p);
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        w = 1'($urandom_range(0, 1));
        a = {1'(p), 7'($urandom_range(0, 127))};
        d = 8'($urandom);
        pushExp(p, w, a, d);
        drivePort(p, 1'b1, w, a, d);
        waiting[p] = 1'b1;
        waited[p]  = 0;
        waitCyc[p] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit abort;

        checkCount  = 0;
        failCount   = 0;
        exclViol    = 0;
        idleBusViol = 0;
        weCycles    = 0;
        for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
        reset_n = 1'b0;
        memInit = 1'b1;
        drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset state
        repeat (3) tick();
        checkVal("resetOuts", outsVec(), 0);
        memInit = 1'b0;
        reset_n = 1'b1;
        tick();
        checkVal("postResetIdle", outsVec(), 0);

        // Preload memory through the arbiter
        doAccess(0, 1'b1, 8'h10, 8'hA5);
        doAccess(0, 1'b1, 8'h01, 8'h5A);
        doAccess(1, 1'b1, 8'h81, 8'hC3);
        tick();

        // Single read on port 0
        pushExp(0, 1'b0, 8'h10, 8'h00);
        drivePort(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        checkVal("t1MemRe",  32'(bus.mem_re), 1);
        checkVal("t1MemWe",  32'(bus.mem_we), 0);
        checkVal("t1Addr",   32'(bus.mem_addr), 32'h10);
        checkVal("t1Gnt0",   32'(bus.gnt0), 1);
        checkVal("t1BusyA",  32'(bus.busy), 1);
        checkVal("t1NoAck",  32'(bus.ack0), 0);
        tick();
        checkVal("t1Ack0",   32'(bus.ack0), 1);
        checkVal("t1Rdata",  32'(bus.rdata), 32'hA5);
        checkVal("t1BusyR",  32'(bus.busy), 1);
        checkVal("t1ReResp", 32'(bus.mem_re), 0);
        drivePort(0, 1'b0, 1'b0, 8'h10, 8'h00);
        tick();
        checkVal("t1IdleBusy", 32'(bus.busy), 0);
        checkVal("t1IdleGnt",  32'({bus.gnt0, bus.gnt1}), 0);

        // Write then back-to-back read on port 1
        weCycles = 0;
        pushExp(1, 1'b1, 8'h80, 8'h3C);
        drivePort(1, 1'b1, 1'b1, 8'h80, 8'h3C);
        tick();
        checkVal("t2MemWe",  32'(bus.mem_we), 1);
        checkVal("t2Wdata",  32'(bus.mem_wdata), 32'h3C);
        checkVal("t2Gnt",    32'({bus.gnt0, bus.gnt1}), 1);
        tick();
        checkVal("t2AckW",   32'(bus.ack1), 1);
        pushExp(1, 1'b0, 8'h80, 8'h00);
        drivePort(1, 1'b1, 1'b0, 8'h80, 8'h00);
        tick();
        checkVal("t2NoBubble", 32'(bus.mem_re), 1);
        checkVal("t2RdAddr",   32'(bus.mem_addr), 32'h80);
        tick();
        checkVal("t2AckR",   32'(bus.ack1), 1);
        checkVal("t2Rdata",  32'(bus.rdata), 32'h3C);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkVal("t2WeOnce", 32'(weCycles), 1);
        tick();

        // Continuous contention: starvation limit governs the grant pattern
        pushExp(0, 1'b0, 8'h01, 8'h00);
        pushExp(1, 1'b0, 8'h81, 8'h00);
        drivePort(0, 1'b1, 1'b0, 8'h01, 8'h00);
        drivePort(1, 1'b1, 1'b0, 8'h81, 8'h00);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c % 2 == 1) begin
                checkVal($sformatf("t3Grant%0d", c / 2), 32'({bus.gnt1, bus.gnt0}),
                         (grantSeq[c / 2] == 1) ? 32'd2 : 32'd1);
                checkVal("t3Access", 32'(bus.mem_re), 1);
            end else begin
                checkVal("t3AckSpacing", 32'(bus.ack0 | bus.ack1), 1);
                if (c == 16) drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);
                else if (c == 18) drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
                else if (bus.ack0) pushExp(0, 1'b0, 8'h01, 8'h00);
                else pushExp(1, 1'b0, 8'h81, 8'h00);
            end
        end
        tick();
        checkVal("t3Idle", 32'(bus.busy), 0);

        // Request withdrawn during ACCESS still completes
        pushExp(0, 1'b0, 8'h10, 8'h00);
        drivePort(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        bus.req0 = 1'b0;
        tick();
        checkVal("t5Ack0", 32'(bus.ack0), 1);
        tick();
        checkVal("t5Idle", 32'(bus.busy), 0);

        // Reset asserted in the middle of a port-1 write
        drivePort(1, 1'b1, 1'b1, 8'h90, 8'h77);
        tick();
        checkVal("t4AccessWe", 32'(bus.mem_we), 1);
        #2 reset_n = 1'b0;
        #1;
        checkVal("t4AsyncWe",   32'(bus.mem_we), 0);
        checkVal("t4AsyncOuts", outsVec(), 0);
        tick();
        checkVal("t4ResetOuts", outsVec(), 0);
        checkVal("t4NoWrite",   32'(tbMem[8'h90]), 0);
        reset_n = 1'b1;
        pushExp(1, 1'b1, 8'h90, 8'h77);
        tick();
        checkVal("t4FreshWe",   32'(bus.mem_we), 1);
        checkVal("t4FreshGnt",  32'(bus.gnt1), 1);
        checkVal("t4FreshAddr", 32'(bus.mem_addr), 32'h90);
        tick();
        checkVal("t4Ack1", 32'(bus.ack1), 1);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Random traffic on both ports, disjoint address halves
        for (int p = 0; p < 2; p++) begin
            waiting[p] = 1'b0;
            idleCnt[p] = int'($urandom_range(0, 3));
        end
        cyc = 0;
        abort = 1'b0;
        while (!abort && (cyc < RAND_CYCLES || waiting[0] || waiting[1])) begin
            tick();
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (waiting[p]) begin
                    waitCyc[p]++;
                    if (bus.ack0 || bus.ack1) waited[p]++;
                    if (ackOf(p)) begin
                        checkVal("randAckBound",
                                 32'(waited[p] <= 2 * (int'(STARVE_LIMIT) + 1)), 1);
                        waiting[p] = 1'b0;
                        idleCnt[p] = int'($urandom_range(0, 3));
                        if (idleCnt[p] == 0 && cyc < RAND_CYCLES) issueRandom(p);
                        else drivePort(p, 1'b0, 1'b0, 8'h00, 8'h00);
                    end else if (waitCyc[p] > 40) begin
                        checkVal("randAckTimeout", 32'(waitCyc[p]), 40);
                        abort = 1'b1;
                    end
                end else if (cyc < RAND_CYCLES) begin
                    if (idleCnt[p] == 0) issueRandom(p);
                    else idleCnt[p]--;
                end
            end
        end
        drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();

        for (int a = 0; a < 256; a++) begin
            checkVal($sformatf("memModel[%0h]", a), 32'(tbMem[a]), 32'(refMem[a]));
        end
        checkVal("q0Drained",   32'(q0.size()), 0);
        checkVal("q1Drained",   32'(q1.size()), 0);
        checkVal("exclusive",   32'(exclViol), 0);
        checkVal("idleBusZero", 32'(idleBusViol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
